// File: rtl/pixie_video_scanout_if.sv
// Frame-buffer read-port bundle between the scan-out engine (master) and the
// dual-port frame buffer's port B (slave).
interface pixie_video_scanout_if;
    logic       fb_en;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;

    modport master (output fb_en, output fb_addr, input fb_data);
    modport slave  (input fb_en, input fb_addr, output fb_data);
endinterface

// File: rtl/pixie_video_scanout.sv
// Pixie raster scan-out: h/v timing, frame-buffer prefetch one byte ahead of need,
// and an MSB-first shifter with horizontal/vertical pixel replication.
module pixie_video_scanout #(
    parameter int unsigned H_TOTAL        = 112,
    parameter int unsigned H_ACTIVE_START = 32,
    parameter int unsigned H_SCALE        = 1,
    parameter int unsigned HSYNC_START    = 0,
    parameter int unsigned HSYNC_LEN      = 12,
    parameter int unsigned V_TOTAL        = 262,
    parameter int unsigned V_ACTIVE_START = 64,
    parameter int unsigned V_ROWS         = 32,
    parameter int unsigned V_SCALE        = 4,
    parameter int unsigned VSYNC_START    = 0,
    parameter int unsigned VSYNC_LEN      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce_pix,
    input  logic                         display_on,
    pixie_video_scanout_if.master        fb,
    output logic                         pix,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         hblank,
    output logic                         vblank,
    output logic                         de,
    output logic                         frame_start
);
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    // Unsigned wrap-around turns a two-sided range test into one compare.
    function automatic logic in_win(input logic [31:0] x, input logic [31:0] start,
                                    input logic [31:0] len);
        return (x - start) < len;
    endfunction

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [6:0]    src_row_q, src_row_d;
    logic [7:0]    rep_q, rep_d;
    logic [1:0]    scale_q, scale_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    byte_q, byte_d;
    logic [7:0]    shift_q, shift_d;
    logic          load_q, load_d;
    logic          pix_q, pix_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic          hblank_q, hblank_d, vblank_q, vblank_d, de_q, de_d, fs_q, fs_d;

    logic [31:0] h_ext, v_ext;
    logic        h_last, v_last, h_act, v_act, byte_end, fetch;
    logic [7:0]  cur;

    always_comb begin
        h_ext    = 32'(h_q);
        v_ext    = 32'(v_q);
        h_last   = (h_ext == H_TOTAL - 1);
        v_last   = (v_ext == V_TOTAL - 1);
        h_act    = in_win(h_ext, H_ACTIVE_START, 64 * H_SCALE);
        v_act    = in_win(v_ext, V_ACTIVE_START, V_ROWS * V_SCALE);
        byte_end = h_act && (32'(scale_q) == H_SCALE - 1) && (bit_q == 3'd7);
        // byte_q[3] set means byte 7 has already been fetched on this line.
        fetch    = v_act && ((h_ext == H_ACTIVE_START - 1) || (byte_end && !byte_q[3]));
        cur      = load_q ? fb.fb_data : shift_q;
    end

    assign fb.fb_en   = ce_pix & ~reset & fetch;
    assign fb.fb_addr = {src_row_q, byte_q[2:0]};

    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        src_row_d = src_row_q;
        rep_d     = rep_q;
        scale_d   = scale_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        load_d    = load_q;
        pix_d     = pix_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        hblank_d  = hblank_q;
        vblank_d  = vblank_q;
        de_d      = de_q;
        fs_d      = ce_pix & h_last & v_last;

        if (ce_pix) begin
            hsync_d  = in_win(h_ext, HSYNC_START, HSYNC_LEN);
            vsync_d  = in_win(v_ext, VSYNC_START, VSYNC_LEN);
            hblank_d = ~h_act;
            vblank_d = ~v_act;
            de_d     = h_act & v_act;
            pix_d    = cur[7] & display_on & h_act & v_act;
            load_d   = fetch;
            shift_d  = cur;

            if (h_act) begin
                if (32'(scale_q) == H_SCALE - 1) begin
                    shift_d = {cur[6:0], 1'b0};
                    scale_d = '0;
                    bit_d   = bit_q + 1'b1;
                end else begin
                    scale_d = scale_q + 1'b1;
                end
            end

            if (fetch) begin
                byte_d = byte_q + 1'b1;
            end

            if (h_last) begin
                h_d     = '0;
                v_d     = v_last ? '0 : v_q + 1'b1;
                byte_d  = '0;
                scale_d = '0;
                bit_d   = '0;
                if (v_act) begin
                    if (32'(rep_q) == V_SCALE - 1) begin
                        rep_d     = '0;
                        src_row_d = src_row_q + 1'b1;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
                if (32'(v_d) == V_ACTIVE_START) begin
                    rep_d     = '0;
                    src_row_d = '0;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q       <= '0;
            v_q       <= '0;
            src_row_q <= '0;
            rep_q     <= '0;
            scale_q   <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            shift_q   <= '0;
            load_q    <= 1'b0;
            pix_q     <= 1'b0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            hblank_q  <= 1'b1;
            vblank_q  <= 1'b1;
            de_q      <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            src_row_q <= src_row_d;
            rep_q     <= rep_d;
            scale_q   <= scale_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            load_q    <= load_d;
            pix_q     <= pix_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            hblank_q  <= hblank_d;
            vblank_q  <= vblank_d;
            de_q      <= de_d;
            fs_q      <= fs_d;
        end
    end

    assign pix         = pix_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign de          = de_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_pixie_video_scanout.sv
// Bench for pixie_video_scanout: a default-parameter instance and an H_SCALE=2 instance,
// each against a 1-clk-latency buffer model and a position-based reference model.
module tb_pixie_video_scanout;
    typedef logic [6:0] vid_t;  // {hsync, vsync, hblank, vblank, de, pix, frame_start}

    logic       clk = 1'b0;
    logic [1:0] rst = 2'b00;
    logic [1:0] ce  = 2'b00;
    logic [1:0] don = 2'b11;
    logic [1:0] pix, hsync, vsync, hblank, vblank, de, frame_start;

    logic [7:0] mem_a [1024];
    logic [7:0] mem_b [1024];

    int   n_cmp = 0;
    int   n_err = 0;
    int   mh [2];
    int   mv [2];
    vid_t last_e [2];
    vid_t q_exp [$];
    int   ticks_a = 0;
    int   fs_count = 0;
    int   fs_at = 0;
    bit   ff_seen = 1'b0;
    int   ff_h = 0;
    int   ff_v = 0;

    always #5 clk = ~clk;

    pixie_video_scanout_if fb_a ();
    pixie_video_scanout_if fb_b ();

    pixie_video_scanout u_dut_a (
        .clk        (clk),
        .reset      (rst[0]),
        .ce_pix     (ce[0]),
        .display_on (don[0]),
        .fb         (fb_a),
        .pix        (pix[0]),
        .hsync      (hsync[0]),
        .vsync      (vsync[0]),
        .hblank     (hblank[0]),
        .vblank     (vblank[0]),
        .de         (de[0]),
        .frame_start(frame_start[0])
    );

    pixie_video_scanout #(.H_SCALE(2)) u_dut_b (
        .clk        (clk),
        .reset      (rst[1]),
        .ce_pix     (ce[1]),
        .display_on (don[1]),
        .fb         (fb_b),
        .pix        (pix[1]),
        .hsync      (hsync[1]),
        .vsync      (vsync[1]),
        .hblank     (hblank[1]),
        .vblank     (vblank[1]),
        .de         (de[1]),
        .frame_start(frame_start[1])
    );

    always @(posedge clk) begin
        if (fb_a.fb_en) fb_a.fb_data <= mem_a[fb_a.fb_addr];
        if (fb_b.fb_en) fb_b.fb_data <= mem_b[fb_b.fb_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (h=%0d v=%0d)", tag, obs, exp,
                   mh[0], mv[0]);
        end
    endtask

    function automatic vid_t get_vid(input int sel);
        return {hsync[sel], vsync[sel], hblank[sel], vblank[sel], de[sel], pix[sel],
                frame_start[sel]};
    endfunction

    // Reference: derive every output from the raster position with plain arithmetic.
    function automatic vid_t model(input int sel, input int h, input int v);
        int s, px, idx;
        logic hact, vact, p;
        logic [7:0] d;
        s    = (sel == 1) ? 2 : 1;
        hact = (h >= 32) && (h < 32 + 64 * s);
        vact = (v >= 64) && (v < 192);
        p    = 1'b0;
        if (hact && vact) begin
            px  = (h - 32) / s;
            idx = ((v - 64) / 4) * 8 + px / 8;
            d   = (sel == 1) ? mem_b[idx] : mem_a[idx];
            p   = d[7 - (px % 8)] & don[sel];
        end
        return {logic'(h < 12), logic'(v < 16), !hact, !vact, hact && vact, p,
                logic'(h == 111 && v == 261)};
    endfunction

    function automatic int fetch_addr(input int sel, input int h, input int v);
        int s, off, row;
        s = (sel == 1) ? 2 : 1;
        if (v < 64 || v >= 192) return -1;
        row = (v - 64) / 4;
        if (h == 31) return row * 8;
        off = h - 32;
        if (off >= 0 && off < 64 * s && (off % (8 * s)) == 8 * s - 1 && off / (8 * s) < 7)
            return row * 8 + off / (8 * s) + 1;
        return -1;
    endfunction

    task automatic step(input int sel, input bit ce_v);
        int   fa;
        logic en_obs;
        logic [9:0] addr_obs;
        vid_t e;
        ce[sel] = ce_v;
        @(negedge clk);
        en_obs   = (sel == 1) ? fb_b.fb_en : fb_a.fb_en;
        addr_obs = (sel == 1) ? fb_b.fb_addr : fb_a.fb_addr;
        fa       = ce_v ? fetch_addr(sel, mh[sel], mv[sel]) : -1;
        check("fb_en", 32'(en_obs), 32'(fa >= 0));
        if (fa >= 0) check("fb_addr", 32'(addr_obs), 32'(fa));
        if (sel == 0 && en_obs && !ff_seen) begin
            ff_seen = 1'b1;
            ff_h    = mh[0];
            ff_v    = mv[0];
        end
        if (ce_v) q_exp.push_back(model(sel, mh[sel], mv[sel]));
        @(posedge clk);
        #1;
        if (ce_v) begin
            e = q_exp.pop_front();
            check("video", 32'(get_vid(sel)), 32'(e));
            last_e[sel] = {e[6:1], 1'b0};
            if (sel == 0) begin
                ticks_a++;
                if (frame_start[0]) begin
                    fs_count++;
                    fs_at = ticks_a;
                end
            end
            mh[sel]++;
            if (mh[sel] == 112) begin
                mh[sel] = 0;
                mv[sel] = (mv[sel] == 261) ? 0 : mv[sel] + 1;
            end
        end else begin
            check("hold", 32'(get_vid(sel)), 32'(last_e[sel]));
        end
    endtask

    task automatic do_reset(input int sel);
        logic [9:0] addr_obs;
        logic en_obs;
        rst[sel] = 1'b1;
        @(posedge clk);
        #1;
        rst[sel]    = 1'b0;
        mh[sel]     = 0;
        mv[sel]     = 0;
        last_e[sel] = 7'b0011000;
        en_obs      = (sel == 1) ? fb_b.fb_en : fb_a.fb_en;
        addr_obs    = (sel == 1) ? fb_b.fb_addr : fb_a.fb_addr;
        check("rst_video", 32'(get_vid(sel)), 32'(last_e[sel]));
        check("rst_fb_en", 32'(en_obs), 32'd0);
        check("rst_fb_addr", 32'(addr_obs), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        mem_a[0] = 8'hA5;
        for (int i = 8; i < 16; i++) mem_a[i] = 8'hFF;
        mem_b[0] = 8'h80; mem_b[1] = 8'h41; mem_b[2] = 8'h22; mem_b[3] = 8'h13;
        mem_b[4] = 8'h0F; mem_b[5] = 8'hF0; mem_b[6] = 8'hAA; mem_b[7] = 8'h55;

        do_reset(0);
        do_reset(1);

        // Full frame at ce every clk: timing, A5 pattern, row mapping, last-row addresses.
        repeat (29344) step(0, 1'b1);
        check("frame_start_count", 32'(fs_count), 32'd1);
        check("frame_period", 32'(fs_at), 32'd29344);
        repeat (3) step(0, 1'b0);

        // Display disabled over an all-ones buffer, up to line 100 h 50.
        don[0] = 1'b0;
        for (int i = 0; i < 1024; i++) mem_a[i] = 8'hFF;
        while (!(mv[0] == 100 && mh[0] == 50)) step(0, 1'b1);

        // Mid-line reset, then a new frame with stalls in ce_pix across line 64.
        don[0] = 1'b1;
        ce[0]  = 1'b1;
        do_reset(0);
        ff_seen = 1'b0;
        while (!(mv[0] == 64 && mh[0] == 40)) begin
            if (mv[0] == 64) begin
                step(0, 1'b0);
                step(0, 1'b0);
            end
            step(0, 1'b1);
        end
        check("first_fetch_seen", 32'(ff_seen), 32'd1);
        check("first_fetch_h", 32'(ff_h), 32'd31);
        check("first_fetch_v", 32'(ff_v), 32'd64);

        // H_SCALE=2 instance with ce_pix every third clk.
        while (!(mv[1] == 66 && mh[1] == 0)) begin
            step(1, 1'b0);
            step(1, 1'b0);
            step(1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
